voice_scheduler: RTL and testbench
==================================

Name: voice_scheduler

Overview:
- Allocation controller between the song reader and a bank of NUM_VOICES note players.
- Accepts note requests and selects a free voice, lowest index first.
- Drives a one-cycle one-hot load pulse with registered note/duration, then waits for the chosen voice to report playing.
- Also publishes the active-voice count for the mixer's volume scaling and counts dropped requests.

Parameters:
- NUM_VOICES, 3, number of note players managed (2..8)
- NOTE_W, 6, note code width
- DUR_W, 6, duration width
- ACK_TIMEOUT, 8, cycles to wait for the selected voice's playing flag before abandoning (>=2)
- AGE_W, 4, per-voice age counter width (saturating)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- play  in  1  play enable; low blocks acceptance
- load_new_note  in  1  request strobe from song reader
- note_to_load  in  NOTE_W  requested note
- duration_to_load  in  DUR_W  requested duration
- voice_playing  in  NUM_VOICES  playing flags from the note players, bit i = voice i
- req_ready  out  1  high when a request will be accepted this cycle
- voice_load  out  NUM_VOICES  one-hot load pulse to the note players
- note_out  out  NOTE_W  registered note shared by all players
- duration_out  out  DUR_W  registered duration shared by all players
- active_count  out  4  registered popcount of voice_playing
- drop_count  out  8  saturating count of dropped requests
- ack_error  out  1  sticky: a load timed out without ack

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE.
  - All outputs and internal registers are cleared to 0, including ages, drop_count and ack_error.
  - Applies from any state, including mid-issue; a pending load is discarded and voice_load is 0 the next cycle.
- States: IDLE, ISSUE, WAIT_ACK.
  - req_ready = (state==IDLE) && play.
- Accept happens at edge T when load_new_note && req_ready:
  - Latch note_to_load and duration_to_load into note_out and duration_out. These hold until the next accept.
  - Latch sel = lowest index i with voice_playing[i]==0, sampled at T.
  - Go to ISSUE.
- All voices busy at accept:
  - Behaviour depends on VOICE_STEAL_EN (see Optional Feature).
- ISSUE (cycle T+1):
  - voice_load = one-hot(sel) for exactly one cycle.
  - Age update: age[sel] is cleared to 0; every other voice's age increments, saturating at 2^AGE_W-1.
  - Go to WAIT_ACK; the timer loads 0.
- WAIT_ACK:
  - If voice_playing[sel]==1, go to IDLE; req_ready is high in the following cycle.
  - Otherwise the timer increments. When timer reaches ACK_TIMEOUT-1 with no ack, set ack_error and go to IDLE.
  - Minimum accept-to-accept spacing is 3 cycles.
- Dropped requests: load_new_note high while play==1 and req_ready==0 increments drop_count, saturating at 255.
  - Requests while play==0 are ignored and not counted.
- play falling in ISSUE/WAIT_ACK: the in-flight load completes normally; no new accept until play returns high.
- active_count = popcount(voice_playing) registered, 1-cycle latency.
- voice_load is never multi-hot. voice_load is 0 in IDLE and WAIT_ACK.

Optional Feature:
- VOICE_STEAL_EN defined:
  - With all voices busy at accept, sel = voice with the largest age; ties go to the lowest index.
  - The request is issued normally. In WAIT_ACK the stolen voice is already playing, so it acks on the first WAIT_ACK cycle.
- VOICE_STEAL_EN undefined:
  - With all voices busy, the request is not accepted. drop_count increments, state stays IDLE, and note_out/duration_out are unchanged.
  - Age logic may be omitted.

Test Plan:
- Reset low for 2 cycles, then high → all outputs 0, req_ready==1 once play==1.
- voice_playing=3'b000, strobe note 6'd20 dur 6'd8 → next cycle voice_load=3'b001 and note_out=20; voice_playing[0] raised at T+3 → req_ready high at T+4.
- voice_playing=3'b011, strobe → voice_load=3'b100. voice_playing=3'b101 → voice_load=3'b010.
- Two strobes on consecutive cycles with voices free → first issues, second dropped, drop_count=1.
- Selected voice never acks, ACK_TIMEOUT=8 → ack_error=1 and IDLE after 8 WAIT_ACK cycles; reset low mid-ISSUE → voice_load=0 next cycle, ack_error=0.
- voice_playing=3'b111:
  - With VOICE_STEAL_EN, after issue order 0,1,2, strobe → voice_load=3'b001 (oldest).
  - Without VOICE_STEAL_EN → no pulse, drop_count increments.

Source files
------------

// File: rtl/voice_scheduler.sv
// voice_scheduler
//   Hands note requests from the song reader to a bank of NUM_VOICES note
//   players. A request is accepted only in IDLE while play is high; the
//   lowest-index free voice is chosen, a one-cycle one-hot load pulse is
//   issued with the registered note/duration, and the scheduler then waits
//   (up to ACK_TIMEOUT cycles) for that voice to report playing.
//
//   Optional feature macro: VOICE_STEAL_EN
//     defined   - with every voice busy the oldest voice (largest age, lowest
//                 index on ties) is stolen; adds the AGE_W parameter and the
//                 per-voice age counters.
//     undefined - with every voice busy the request is dropped and counted.
//
// Ports
//   clk               system clock
//   reset             synchronous, active-low reset
//   play              play enable; low blocks acceptance (requests ignored)
//   load_new_note     request strobe
//   note_to_load      requested note
//   duration_to_load  requested duration
//   voice_playing     playing flags from the note players (bit i = voice i)
//   req_ready         high when a request would be accepted this cycle
//   voice_load        one-hot load pulse, high only in ISSUE
//   note_out          registered note shared by all players
//   duration_out      registered duration shared by all players
//   active_count      registered popcount of voice_playing
//   drop_count        saturating count of dropped requests
//   ack_error         sticky: a load timed out without ack
module voice_scheduler #(
  parameter int NUM_VOICES  = 3,
  parameter int NOTE_W      = 6,
  parameter int DUR_W       = 6,
  parameter int ACK_TIMEOUT = 8
`ifdef VOICE_STEAL_EN
  , parameter int AGE_W     = 4
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play,
  input  logic                  load_new_note,
  input  logic [NOTE_W-1:0]     note_to_load,
  input  logic [DUR_W-1:0]      duration_to_load,
  input  logic [NUM_VOICES-1:0] voice_playing,
  output logic                  req_ready,
  output logic [NUM_VOICES-1:0] voice_load,
  output logic [NOTE_W-1:0]     note_out,
  output logic [DUR_W-1:0]      duration_out,
  output logic [3:0]            active_count,
  output logic [7:0]            drop_count,
  output logic                  ack_error
);

  localparam int SEL_W = $clog2(NUM_VOICES);
  localparam int TMR_W = $clog2(ACK_TIMEOUT) + 1;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ISSUE    = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [NOTE_W-1:0]     note_q, note_d;
  logic [DUR_W-1:0]      dur_q, dur_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [7:0]            drop_q, drop_d;
  logic                  ack_err_q, ack_err_d;
  logic [3:0]            active_q, active_d;
  logic [NUM_VOICES-1:0] sel_oh;

  logic                  free_found;
  logic [SEL_W-1:0]      free_sel;
  logic [SEL_W-1:0]      issue_sel;
  logic                  can_issue;
  logic                  accept;
  logic                  drop_evt;
  logic                  sel_ack;

  // Lowest-index free voice: scan downwards so the last hit is the lowest.
  always_comb begin
    free_found = 1'b0;
    free_sel   = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!voice_playing[i]) begin
        free_found = 1'b1;
        free_sel   = SEL_W'(i);
      end
    end
  end

`ifdef VOICE_STEAL_EN
  logic [AGE_W-1:0] age_q [NUM_VOICES];
  logic [SEL_W-1:0] steal_sel;

  // Oldest voice; strict '>' keeps the lowest index on ties.
  always_comb begin
    steal_sel = '0;
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (age_q[i] > age_q[steal_sel]) steal_sel = SEL_W'(i);
    end
  end

  // Ages move only on an issue: the loaded voice restarts at 0, the rest
  // grow and saturate.
  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_age
    always_ff @(posedge clk) begin
      if (!reset) begin
        age_q[gi] <= '0;
      end else if (state_q == ST_ISSUE) begin
        if (sel_q == SEL_W'(gi))  age_q[gi] <= '0;
        else if (age_q[gi] != '1) age_q[gi] <= age_q[gi] + 1'b1;
      end
    end
  end

  assign issue_sel = free_found ? free_sel : steal_sel;
  assign can_issue = 1'b1;
`else
  assign issue_sel = free_sel;
  assign can_issue = free_found;
`endif

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_sel_oh
    assign sel_oh[gi] = (sel_q == SEL_W'(gi));
  end

  assign req_ready  = (state_q == ST_IDLE) && play;
  assign accept     = load_new_note && req_ready && can_issue;
  // A busy scheduler or an all-busy bank (without stealing) both drop.
  assign drop_evt   = load_new_note && play && !accept;
  assign sel_ack    = |(voice_playing & sel_oh);
  assign voice_load = (state_q == ST_ISSUE) ? sel_oh : '0;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    note_d    = note_q;
    dur_d     = dur_q;
    timer_d   = timer_q;
    ack_err_d = ack_err_q;
    drop_d    = drop_q;
    active_d  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      active_d = active_d + {3'b000, voice_playing[i]};
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          note_d  = note_to_load;
          dur_d   = duration_to_load;
          sel_d   = issue_sel;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // Ack wins over timeout when both land on the last cycle.
        if (sel_ack) begin
          state_d = ST_IDLE;
        end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
          ack_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (drop_evt && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      note_q    <= '0;
      dur_q     <= '0;
      timer_q   <= '0;
      drop_q    <= '0;
      ack_err_q <= 1'b0;
      active_q  <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      note_q    <= note_d;
      dur_q     <= dur_d;
      timer_q   <= timer_d;
      drop_q    <= drop_d;
      ack_err_q <= ack_err_d;
      active_q  <= active_d;
    end
  end

  assign note_out     = note_q;
  assign duration_out = dur_q;
  assign drop_count   = drop_q;
  assign ack_error    = ack_err_q;
  assign active_count = active_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Self-checking bench for voice_scheduler (default parameters).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_voice_scheduler;

  localparam int NV  = 3;
  localparam int ATO = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       play;
  logic       load_new_note;
  logic [5:0] note_to_load;
  logic [5:0] duration_to_load;
  logic [2:0] voice_playing;
  logic       req_ready;
  logic [2:0] voice_load;
  logic [5:0] note_out;
  logic [5:0] duration_out;
  logic [3:0] active_count;
  logic [7:0] drop_count;
  logic       ack_error;

  voice_scheduler dut (
    .clk              (clk),
    .reset            (reset),
    .play             (play),
    .load_new_note    (load_new_note),
    .note_to_load     (note_to_load),
    .duration_to_load (duration_to_load),
    .voice_playing    (voice_playing),
    .req_ready        (req_ready),
    .voice_load       (voice_load),
    .note_out         (note_out),
    .duration_out     (duration_out),
    .active_count     (active_count),
    .drop_count       (drop_count),
    .ack_error        (ack_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int         m_drop;
  bit         m_err;
  int         m_age [NV];
  logic [5:0] m_note;
  logic [5:0] m_dur;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_drop = 0;
    m_err  = 1'b0;
    m_note = '0;
    m_dur  = '0;
    for (int i = 0; i < NV; i++) m_age[i] = 0;
  endtask

  function automatic void bump_drop();
    if (m_drop < 255) m_drop++;
  endfunction

  // Voice the scheduler should pick for a playing pattern; -1 means drop.
  function automatic int ref_sel(input logic [2:0] vp);
    int best;
    best = 0;
    for (int i = 0; i < NV; i++) if (!vp[i]) return i;
`ifdef VOICE_STEAL_EN
    for (int i = 1; i < NV; i++) if (m_age[i] > m_age[best]) best = i;
    return best;
`else
    return -1;
`endif
  endfunction

  // One request. k = cycles into WAIT_ACK before the selected voice acks,
  // -1 for never. extra = hold the strobe into the busy ISSUE cycle.
  task automatic run_txn(input logic [2:0] vp, input logic [5:0] note,
                         input logic [5:0] dur, input int k, input bit extra);
    int         s;
    int         kk;
    logic [2:0] oh;
    s = ref_sel(vp);
    voice_playing    = vp;
    note_to_load     = note;
    duration_to_load = dur;
    load_new_note    = 1'b1;
    chk("ready_idle", {31'b0, req_ready}, 1);
    step();
    chk("active_count", {28'b0, active_count}, $countones(vp));
    if (s < 0) begin
      bump_drop();
      load_new_note = 1'b0;
      chk("no_pulse", {29'b0, voice_load}, 0);
      chk("drop_allbusy", {24'b0, drop_count}, m_drop);
      chk("note_hold", {26'b0, note_out}, m_note);
      chk("ready_stay", {31'b0, req_ready}, 1);
      $display("txn vp=%b note=%0d -> dropped, drop_count=%0d", vp, note, drop_count);
      return;
    end
    oh     = 3'b001 << s;
    m_note = note;
    m_dur  = dur;
    for (int i = 0; i < NV; i++) m_age[i] = (i == s) ? 0 : ((m_age[i] < 15) ? m_age[i] + 1 : 15);
    chk("voice_load", {29'b0, voice_load}, oh);
    chk("note_out", {26'b0, note_out}, m_note);
    chk("duration_out", {26'b0, duration_out}, m_dur);
    chk("ready_issue", {31'b0, req_ready}, 0);
    load_new_note = extra;
    if (extra) bump_drop();
    step();
    load_new_note = 1'b0;
    chk("pulse_one_cycle", {29'b0, voice_load}, 0);
    chk("drop_count", {24'b0, drop_count}, m_drop);
    kk = vp[s] ? 0 : k;  // a stolen voice is already playing
    if (kk >= 0) begin
      repeat (kk) step();
      voice_playing = vp | oh;
      chk("ready_before_ack", {31'b0, req_ready}, 0);
      step();
      chk("ready_after_ack", {31'b0, req_ready}, 1);
      chk("ack_error", {31'b0, ack_error}, m_err);
    end else begin
      repeat (ATO - 1) step();
      chk("ready_pre_timeout", {31'b0, req_ready}, 0);
      step();
      m_err = 1'b1;
      chk("ready_timeout", {31'b0, req_ready}, 1);
      chk("ack_error_set", {31'b0, ack_error}, 1);
    end
    $display("txn vp=%b note=%0d dur=%0d k=%0d -> load=%b drop=%0d err=%0d",
             vp, note, dur, k, oh, drop_count, ack_error);
  endtask

  initial begin
    reset = 1'b0; play = 1'b0; load_new_note = 1'b0;
    note_to_load = '0; duration_to_load = '0; voice_playing = '0;
    model_reset();
    @(negedge clk);
    step();
    step();
    chk("rst_voice_load", {29'b0, voice_load}, 0);
    chk("rst_note", {26'b0, note_out}, 0);
    chk("rst_dur", {26'b0, duration_out}, 0);
    chk("rst_active", {28'b0, active_count}, 0);
    chk("rst_drop", {24'b0, drop_count}, 0);
    chk("rst_ack_error", {31'b0, ack_error}, 0);
    chk("rst_ready_noplay", {31'b0, req_ready}, 0);
    reset = 1'b1;
    play  = 1'b1;
    step();
    chk("ready_after_rst", {31'b0, req_ready}, 1);

    // Directed selection patterns
    run_txn(3'b000, 6'd20, 6'd8, 0, 1'b0);
    run_txn(3'b011, 6'd33, 6'd2, 1, 1'b0);
    run_txn(3'b101, 6'd5,  6'd63, 2, 1'b0);
    // Back-to-back strobe: second one dropped
    run_txn(3'b000, 6'd9, 6'd9, 0, 1'b1);
    // Ack on the very last timer cycle is still an ack
    run_txn(3'b010, 6'd11, 6'd4, ATO - 1, 1'b0);
    // Issue order 0,1,2 then all busy
    run_txn(3'b000, 6'd1, 6'd1, 0, 1'b0);
    run_txn(3'b001, 6'd2, 6'd2, 0, 1'b0);
    run_txn(3'b011, 6'd3, 6'd3, 0, 1'b0);
    run_txn(3'b111, 6'd44, 6'd7, 0, 1'b0);
    // Never acked: timeout
    run_txn(3'b000, 6'd50, 6'd10, -1, 1'b0);

    // play low: request ignored and not counted
    play = 1'b0;
    load_new_note = 1'b1;
    voice_playing = 3'b000;
    step();
    chk("play_low_ready", {31'b0, req_ready}, 0);
    chk("play_low_pulse", {29'b0, voice_load}, 0);
    chk("play_low_drop", {24'b0, drop_count}, m_drop);
    load_new_note = 1'b0;
    play = 1'b1;
    step();
    $display("play-low request ignored, drop_count=%0d", drop_count);

    // Reset during ISSUE
    load_new_note = 1'b1;
    note_to_load  = 6'd17;
    voice_playing = 3'b000;
    step();
    load_new_note = 1'b0;
    chk("mid_issue_pulse", {29'b0, voice_load}, 3'b001);
    reset = 1'b0;
    step();
    model_reset();
    chk("rst_mid_pulse", {29'b0, voice_load}, 0);
    chk("rst_mid_ack_error", {31'b0, ack_error}, 0);
    chk("rst_mid_drop", {24'b0, drop_count}, 0);
    chk("rst_mid_note", {26'b0, note_out}, 0);
    reset = 1'b1;
    step();
    chk("rst_mid_ready", {31'b0, req_ready}, 1);
    $display("reset during ISSUE cleared state");

    // Randomized requests
    for (int n = 0; n < 40; n++) begin
      logic [2:0] vp;
      int         k;
      bit         ex;
      vp = 3'($urandom_range(0, 7));
      k  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, ATO - 1));
      ex = ($urandom_range(0, 3) == 0);
      run_txn(vp, 6'($urandom), 6'($urandom), k, ex);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
